// File: rtl/reg_wb_ctrl_pkg.sv
// Shared constants and types for the integer register-file write-back controller.
package reg_wb_ctrl_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  localparam logic [AW-1:0] X0_ADDR = '0;

  typedef enum logic {
    SRC_LSU = 1'b0,
    SRC_ALU = 1'b1
  } src_e;
endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Producer handshakes, scoreboard query ports and register-file write port of reg_wb_ctrl.
interface reg_wb_ctrl_if;
  import reg_wb_ctrl_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd_addr;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd_addr;
  logic [XLEN-1:0] lsu_data;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd_addr;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_busy;
  logic            rf_write_en;
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd;
  logic [63:0]     wb_count;

  modport slave (
    input  alu_valid, alu_rd_addr, alu_data,
    input  lsu_valid, lsu_rd_addr, lsu_data,
    input  iss_valid, iss_rd_addr, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready,
    output rs1_busy, rs2_busy, rd_busy,
    output rf_write_en, rf_rd_addr, rf_rd, wb_count
  );

  modport master (
    output alu_valid, alu_rd_addr, alu_data,
    output lsu_valid, lsu_rd_addr, lsu_data,
    output iss_valid, iss_rd_addr, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready,
    input  rs1_busy, rs2_busy, rd_busy,
    input  rf_write_en, rf_rd_addr, rf_rd, wb_count
  );
endinterface

// File: rtl/reg_wb_ctrl_wb_scoreboard.sv
// Busy scoreboard: one pending-write bit per architectural register, x0 never busy.
module wb_scoreboard
  import reg_wb_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_rs1_addr,
  input  logic [AW-1:0] i_rs2_addr,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  output logic          o_rd_busy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Set is applied after clear so a same-edge reissue keeps the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[X0_ADDR] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_rs1_busy = r_busy[i_rs1_addr];
  assign o_rs2_busy = r_busy[i_rs2_addr];
  assign o_rd_busy  = r_busy[i_rd_addr];
endmodule

// File: rtl/reg_wb_ctrl.sv
// Round-robin ALU/LSU write-back arbiter with a registered register-file write port.
module reg_wb_ctrl
  import reg_wb_ctrl_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  reg_wb_ctrl_if.slave bus
);
  src_e            r_pref;
  src_e            w_pref_nxt;
  logic            w_contend;
  logic            w_alu_ready;
  logic            w_lsu_ready;
  logic            w_alu_xfer;
  logic            w_lsu_xfer;
  logic [AW-1:0]   w_sel_addr;
  logic [XLEN-1:0] w_sel_data;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_data;
  logic [63:0]     r_cnt;
  logic            w_rs1_busy;
  logic            w_rs2_busy;
  logic            w_rd_busy;

  assign w_contend   = bus.alu_valid && bus.lsu_valid;
  assign w_alu_ready = !w_contend || (r_pref == SRC_ALU);
  assign w_lsu_ready = !w_contend || (r_pref == SRC_LSU);
  assign w_alu_xfer  = bus.alu_valid && w_alu_ready;
  assign w_lsu_xfer  = bus.lsu_valid && w_lsu_ready;

  // Pointer only moves on a contended grant, handing priority to the loser.
  always_comb begin
    w_pref_nxt = r_pref;
    w_sel_addr = bus.lsu_rd_addr;
    w_sel_data = bus.lsu_data;
    if (w_contend) begin
      case (r_pref)
        SRC_LSU: w_pref_nxt = SRC_ALU;
        default: w_pref_nxt = SRC_LSU;
      endcase
    end
    if (w_alu_xfer) begin
      w_sel_addr = bus.alu_rd_addr;
      w_sel_data = bus.alu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pref <= SRC_LSU;
    else        r_pref <= w_pref_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_alu_xfer || w_lsu_xfer) begin
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
        r_we   <= (w_sel_addr != X0_ADDR);
      end else begin
        r_we   <= 1'b0;
      end
      if (r_we) r_cnt <= r_cnt + 64'd1;
    end
  end

  wb_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (bus.iss_valid && (bus.iss_rd_addr != X0_ADDR)),
    .i_set_addr (bus.iss_rd_addr),
    .i_clr_en   (r_we),
    .i_clr_addr (r_addr),
    .i_rs1_addr (bus.rs1_addr),
    .i_rs2_addr (bus.rs2_addr),
    .i_rd_addr  (bus.iss_rd_addr),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_busy  (w_rd_busy)
  );

  assign bus.alu_ready   = w_alu_ready;
  assign bus.lsu_ready   = w_lsu_ready;
  assign bus.rs1_busy    = w_rs1_busy;
  assign bus.rs2_busy    = w_rs2_busy;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.rf_write_en = r_we;
  assign bus.rf_rd_addr  = r_addr;
  assign bus.rf_rd       = r_data;
  assign bus.wb_count    = r_cnt;
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed and randomized checks of reg_wb_ctrl against a transaction-level reference model.
module tb_reg_wb_ctrl;
  import reg_wb_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  reg_wb_ctrl_if ifc ();
  reg_wb_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: pending-write set, next expected write, commit count, who wins a tie.
  bit              m_busy [NREG];
  bit              m_we;
  bit              m_pref_alu;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_rd;
  logic [63:0]     m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issuing onto a busy register is only legal when that register retires on the same edge.
  always @(posedge clk) begin
    if (rst_n && ifc.iss_valid &&
        !(ifc.rf_write_en && ifc.rf_rd_addr == ifc.iss_rd_addr)) begin
      assert (!ifc.rd_busy) else begin
        errors++;
        $error("FAIL iss_protocol: observed rd_busy=1 for x%0d expected 0", ifc.iss_rd_addr);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_we = 1'b0; m_pref_alu = 1'b0; m_addr = '0; m_rd = '0; m_cnt = '0;
  endtask

  task automatic idle();
    ifc.alu_valid = 1'b0; ifc.alu_rd_addr = '0; ifc.alu_data = '0;
    ifc.lsu_valid = 1'b0; ifc.lsu_rd_addr = '0; ifc.lsu_data = '0;
    ifc.iss_valid = 1'b0; ifc.iss_rd_addr = '0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle(input string tag);
    bit both, g_alu, g_lsu;
    #3;
    both  = ifc.alu_valid && ifc.lsu_valid;
    g_alu = ifc.alu_valid && (!both || m_pref_alu);
    g_lsu = ifc.lsu_valid && (!both || !m_pref_alu);
    if (ifc.alu_valid) chk({tag, ":alu_ready"}, ifc.alu_ready, g_alu);
    if (ifc.lsu_valid) chk({tag, ":lsu_ready"}, ifc.lsu_ready, g_lsu);
    if (!ifc.alu_valid && !ifc.lsu_valid)
      chk({tag, ":idle_ready"}, {ifc.alu_ready, ifc.lsu_ready}, 2'b11);
    chk({tag, ":rs1_busy"}, ifc.rs1_busy, m_busy[ifc.rs1_addr]);
    chk({tag, ":rs2_busy"}, ifc.rs2_busy, m_busy[ifc.rs2_addr]);
    chk({tag, ":rd_busy"},  ifc.rd_busy,  m_busy[ifc.iss_rd_addr]);
    @(posedge clk);
    if (m_we) begin
      m_busy[m_addr] = 1'b0;
      m_cnt++;
    end
    if (ifc.iss_valid && ifc.iss_rd_addr != 0) m_busy[ifc.iss_rd_addr] = 1'b1;
    if (both) m_pref_alu = !m_pref_alu;
    m_we = 1'b0;
    if (g_alu) begin
      m_addr = ifc.alu_rd_addr; m_rd = ifc.alu_data; m_we = (ifc.alu_rd_addr != 0);
    end else if (g_lsu) begin
      m_addr = ifc.lsu_rd_addr; m_rd = ifc.lsu_data; m_we = (ifc.lsu_rd_addr != 0);
    end
    #1;
    chk({tag, ":we"},    ifc.rf_write_en, m_we);
    chk({tag, ":addr"},  ifc.rf_rd_addr,  m_addr);
    chk({tag, ":data"},  ifc.rf_rd,       m_rd);
    chk({tag, ":count"}, ifc.wb_count,    m_cnt);
  endtask

  initial begin
    logic [63:0] c0;
    int pulses;
    bit legal;
    int unsigned a;

    idle();
    ifc.rs1_addr = '0; ifc.rs2_addr = '0;
    model_reset();
    rst_n = 1'b0;
    #12;
    chk("rst:we", ifc.rf_write_en, 1'b0);
    chk("rst:addr", ifc.rf_rd_addr, '0);
    chk("rst:data", ifc.rf_rd, '0);
    chk("rst:count", ifc.wb_count, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU result
    ifc.alu_valid = 1'b1; ifc.alu_rd_addr = 5'd5; ifc.alu_data = 64'hDEAD_BEEF;
    cycle("single");
    idle();
    chk("single:we_exp", ifc.rf_write_en, 1'b1);
    chk("single:addr_exp", ifc.rf_rd_addr, 5'd5);
    chk("single:data_exp", ifc.rf_rd, 64'hDEAD_BEEF);
    cycle("single_after");
    chk("single:count_exp", ifc.wb_count, 64'd1);

    // Asynchronous reset while a write is on the port
    ifc.alu_valid = 1'b1; ifc.alu_rd_addr = 5'd9; ifc.alu_data = 64'h1234;
    ifc.iss_valid = 1'b1; ifc.iss_rd_addr = 5'd12;
    cycle("pre_rst");
    idle();
    chk("pre_rst:we_high", ifc.rf_write_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst:we", ifc.rf_write_en, 1'b0);
    chk("arst:addr", ifc.rf_rd_addr, '0);
    chk("arst:data", ifc.rf_rd, '0);
    chk("arst:count", ifc.wb_count, '0);
    for (int i = 0; i < NREG; i++) begin
      ifc.rs1_addr = AW'(i);
      #1 chk("arst:rs1_busy", ifc.rs1_busy, 1'b0);
    end
    ifc.rs1_addr = '0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: LSU preferred out of reset, then strict alternation
    ifc.alu_valid = 1'b1; ifc.alu_rd_addr = 5'd3;
    ifc.lsu_valid = 1'b1; ifc.lsu_rd_addr = 5'd4;
    for (int i = 0; i < 4; i++) begin
      ifc.alu_data = 64'hA000 + 64'(i);
      ifc.lsu_data = 64'hB000 + 64'(i);
      #2;
      chk("contend:lsu_grant", ifc.lsu_ready, (i % 2 == 0));
      chk("contend:alu_grant", ifc.alu_ready, (i % 2 == 1));
      cycle("contend");
      chk("contend:addr_exp", ifc.rf_rd_addr, (i % 2 == 0) ? 5'd4 : 5'd3);
    end
    idle();
    cycle("contend_drain");

    // Scoreboard: set on issue, clear on write, set wins over same-edge clear
    ifc.rs1_addr = 5'd7; ifc.rs2_addr = 5'd0;
    ifc.iss_valid = 1'b1; ifc.iss_rd_addr = 5'd7;
    cycle("sb_iss");
    ifc.iss_valid = 1'b0;
    chk("sb:set", ifc.rs1_busy, 1'b1);
    cycle("sb_t1");
    cycle("sb_t2");
    ifc.alu_valid = 1'b1; ifc.alu_rd_addr = 5'd7; ifc.alu_data = 64'h77;
    cycle("sb_t3");
    ifc.alu_valid = 1'b0;
    chk("sb:still_busy_at_write", ifc.rs1_busy, 1'b1);
    cycle("sb_t4");
    chk("sb:cleared", ifc.rs1_busy, 1'b0);
    ifc.iss_valid = 1'b1;
    cycle("sb_reiss");
    ifc.iss_valid = 1'b0;
    ifc.alu_valid = 1'b1;
    cycle("sb_w2");
    ifc.alu_valid = 1'b0;
    ifc.iss_valid = 1'b1;
    cycle("sb_same_edge");
    ifc.iss_valid = 1'b0;
    chk("sb:set_wins", ifc.rs1_busy, 1'b1);
    ifc.alu_valid = 1'b1;
    cycle("sb_w3");
    idle();
    cycle("sb_w3_commit");
    chk("sb:final_clear", ifc.rs1_busy, 1'b0);

    // x0 write is swallowed
    c0 = m_cnt;
    ifc.lsu_valid = 1'b1; ifc.lsu_rd_addr = 5'd0; ifc.lsu_data = 64'h1;
    ifc.iss_valid = 1'b1; ifc.iss_rd_addr = 5'd0; ifc.rs1_addr = 5'd0;
    cycle("x0");
    idle();
    chk("x0:we", ifc.rf_write_en, 1'b0);
    chk("x0:busy0", ifc.rs1_busy, 1'b0);
    cycle("x0_after");
    chk("x0:count", ifc.wb_count, c0);

    // Back-to-back throughput
    c0 = m_cnt;
    pulses = 0;
    ifc.alu_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ifc.alu_rd_addr = AW'(1 + (i % 31));
      ifc.alu_data = 64'(i) * 64'h0101_0101;
      cycle("thru");
      if (ifc.rf_write_en) pulses++;
    end
    idle();
    cycle("thru_drain");
    chk("thru:pulses", pulses, 100);
    chk("thru:count", ifc.wb_count, c0 + 64'd100);

    // Randomized traffic with legal issue
    for (int i = 0; i < 300; i++) begin
      ifc.alu_valid = ($urandom_range(0, 2) != 0);
      ifc.alu_rd_addr = AW'($urandom_range(0, NREG - 1));
      ifc.alu_data = {$urandom, $urandom};
      ifc.lsu_valid = ($urandom_range(0, 2) != 0);
      ifc.lsu_rd_addr = AW'($urandom_range(0, NREG - 1));
      ifc.lsu_data = {$urandom, $urandom};
      a = $urandom_range(0, NREG - 1);
      legal = !m_busy[a] || (m_we && m_addr == AW'(a));
      ifc.iss_rd_addr = AW'(a);
      ifc.iss_valid = legal && ($urandom_range(0, 1) == 1);
      ifc.rs1_addr = AW'($urandom_range(0, NREG - 1));
      ifc.rs2_addr = AW'($urandom_range(0, NREG - 1));
      cycle("rand");
    end
    idle();
    cycle("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
